// File: rtl/config_port_arbiter.sv
// config_port_arbiter: session-locking N-source config arbiter with output FIFO into ConfigFSM.
// Optional CONFIG_ARB_WORDCOUNT_EN adds a per-session word_count output.
module config_port_arbiter #(
  parameter int NUM_CH      = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 16
)(
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_active,
  input  logic [NUM_CH-1:0]            ch_strobe,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        ConfigWriteData,
  output logic                         ConfigWriteStrobe,
  output logic                         FSM_Reset,
  output logic [$clog2(NUM_CH)-1:0]    grant_id,
  output logic                         busy,
  output logic                         overflow
`ifdef CONFIG_ARB_WORDCOUNT_EN
  ,output logic [31:0]                 word_count
`endif
);
  localparam int GW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(IDLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, HOLDOFF} state_t;
  state_t state, nextState;
  logic [AW:0] wrPtr, rdPtr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] grantData;
  logic [GW-1:0] topCh;
  logic [HW-1:0] holdCnt;
  logic start, grantStb, empty, full, pop, push;
  assign start     = state == IDLE && |ch_active;
  assign grantStb  = state == GRANT && ch_strobe[grant_id];
  assign empty     = wrPtr == rdPtr;
  assign full      = wrPtr[AW] != rdPtr[AW] && wrPtr[AW-1:0] == rdPtr[AW-1:0];
  assign pop       = !empty && out_ready;
  assign push      = grantStb && (!full || pop);
  assign busy      = state != IDLE;
  assign grantData = ch_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  // Highest active index wins
  always_comb begin
    topCh = '0;
    for (int i = 0; i < NUM_CH; i++) if (ch_active[i]) topCh = GW'(i);
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = |ch_active ? GRANT : IDLE;
      GRANT:   nextState = ch_active[grant_id] ? GRANT : DRAIN;
      DRAIN:   nextState = empty && !ConfigWriteStrobe ? HOLDOFF : DRAIN;
      HOLDOFF: nextState = holdCnt == HW'(IDLE_CYCLES - 1) ? IDLE : HOLDOFF;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge CLK) state <= reset ? IDLE : nextState;
  always_ff @(posedge CLK) begin
    if (reset) begin
      wrPtr             <= '0;
      rdPtr             <= '0;
      holdCnt           <= '0;
      grant_id          <= '0;
      FSM_Reset         <= 1'b0;
      ConfigWriteData   <= '0;
      ConfigWriteStrobe <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      FSM_Reset         <= start;
      holdCnt           <= state == HOLDOFF ? holdCnt + 1'b1 : '0;
      ConfigWriteStrobe <= pop;
      if (start) grant_id <= topCh;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr           <= rdPtr + 1'b1;
        ConfigWriteData <= mem[rdPtr[AW-1:0]];
      end
      if (grantStb && full && !pop) overflow <= 1'b1;
    end
  end
  always_ff @(posedge CLK) if (push) mem[wrPtr[AW-1:0]] <= grantData;
`ifdef CONFIG_ARB_WORDCOUNT_EN
  always_ff @(posedge CLK) begin
    if (reset || start) word_count <= '0;
    else if (pop && word_count != '1) word_count <= word_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_config_port_arbiter.sv
// tb_config_port_arbiter: directed vector table plus hand-written session, stall and reset sequences.
module tb_config_port_arbiter;
  logic CLK = 1'b0, reset = 1'b1, rdy = 1'b1;
  logic [2:0] act = 3'b000, stb = 3'b000;
  logic [95:0] chData = '0;
  logic [31:0] cwd;
  logic cws, fsr, busy, ovf;
  logic [1:0] gid;
`ifdef CONFIG_ARB_WORDCOUNT_EN
  logic [31:0] wc;
`endif
  int checks = 0, errors = 0;

  config_port_arbiter dut (
    .CLK(CLK), .reset(reset), .ch_active(act), .ch_strobe(stb), .ch_data(chData),
    .out_ready(rdy), .ConfigWriteData(cwd), .ConfigWriteStrobe(cws), .FSM_Reset(fsr),
    .grant_id(gid), .busy(busy), .overflow(ovf)
`ifdef CONFIG_ARB_WORDCOUNT_EN
    , .word_count(wc)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst; logic [2:0] act, stb; logic [31:0] d;
    logic eStb; logic [31:0] eData; logic eFsr, eBusy; logic [1:0] eGid;
  } vec_t;
  vec_t v [18];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    chk("fsrStbExclusive", {31'b0, fsr & cws}, 32'd0);
  endtask

  task automatic hold(input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk("holdoffBusy", {31'b0, busy}, {31'b0, i < n});
    end
  endtask

  task automatic outChk(input string n, input logic s, input logic [31:0] d);
    chk({n, ".stb"}, {31'b0, cws}, {31'b0, s});
    if (s) chk({n, ".data"}, cwd, d);
  endtask

  task automatic runVecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      reset = v[k].rst; act = v[k].act; stb = v[k].stb; chData = {3{v[k].d}};
      tick();
      chk($sformatf("v%0d.stb", k), {31'b0, cws}, {31'b0, v[k].eStb});
      chk($sformatf("v%0d.data", k), cwd, v[k].eData);
      chk($sformatf("v%0d.fsr", k), {31'b0, fsr}, {31'b0, v[k].eFsr});
      chk($sformatf("v%0d.busy", k), {31'b0, busy}, {31'b0, v[k].eBusy});
      chk($sformatf("v%0d.gid", k), {30'b0, gid}, {30'b0, v[k].eGid});
      chk($sformatf("v%0d.ovf", k), {31'b0, ovf}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{1'b1, 3'b000, 3'b000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 2'd0};
    v[1]  = '{1'b1, 3'b000, 3'b000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 2'd0};
    v[2]  = '{1'b0, 3'b001, 3'b000, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 2'd0};
    v[3]  = '{1'b0, 3'b001, 3'b001, 32'hA5A5_0001, 1'b0, 32'h0,         1'b0, 1'b1, 2'd0};
    v[4]  = '{1'b0, 3'b001, 3'b001, 32'hA5A5_0002, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 2'd0};
    v[5]  = '{1'b0, 3'b001, 3'b001, 32'hA5A5_0003, 1'b1, 32'hA5A5_0002, 1'b0, 1'b1, 2'd0};
    v[6]  = '{1'b0, 3'b001, 3'b000, 32'h0,         1'b1, 32'hA5A5_0003, 1'b0, 1'b1, 2'd0};
    v[7]  = '{1'b0, 3'b001, 3'b000, 32'h0,         1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 2'd0};
    v[8]  = '{1'b0, 3'b000, 3'b000, 32'h0,         1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 2'd0};
    v[9]  = '{1'b0, 3'b000, 3'b000, 32'h0,         1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 2'd0};
    v[10] = '{1'b0, 3'b101, 3'b000, 32'h0,         1'b0, 32'hA5A5_0003, 1'b1, 1'b1, 2'd2};
    v[11] = '{1'b0, 3'b101, 3'b001, 32'hDEAD_BEEF, 1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 2'd2};
    v[12] = '{1'b0, 3'b101, 3'b001, 32'hDEAD_BEEF, 1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 2'd2};
    v[13] = '{1'b0, 3'b101, 3'b000, 32'h0,         1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 2'd2};
    v[14] = '{1'b0, 3'b101, 3'b100, 32'h1234_5678, 1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 2'd2};
    v[15] = '{1'b0, 3'b101, 3'b000, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 1'b1, 2'd2};
    v[16] = '{1'b0, 3'b001, 3'b000, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 1'b1, 2'd2};
    v[17] = '{1'b0, 3'b001, 3'b000, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 1'b1, 2'd2};
    @(negedge CLK);
    runVecs(0, 1);
`ifdef CONFIG_ARB_WORDCOUNT_EN
    chk("wcAfterReset", wc, 32'd0);
`endif
    runVecs(2, 9);
`ifdef CONFIG_ARB_WORDCOUNT_EN
    chk("wcSession", wc, 32'd3);
`endif
    // New requests during hold-off must not be granted early
    act = 3'b101;
    hold(16);
    runVecs(10, 17);
    act = 3'b000;
    hold(16);
    // ch1 session; ch2 raised mid-session must wait
    act = 3'b010; stb = 3'b000;
    tick();
    chk("s4.fsr", {31'b0, fsr}, 32'd1);
    chk("s4.gid", {30'b0, gid}, 32'd1);
    act = 3'b110; stb = 3'b010;
    chData = {32'h2222_0002, 32'h1111_0001, 32'h0};
    tick();
    stb = 3'b100;
    tick();
    outChk("s4.ch1Word", 1'b1, 32'h1111_0001);
    chk("s4.gidHeld", {30'b0, gid}, 32'd1);
    stb = 3'b000;
    tick();
    outChk("s4.ch2Ignored", 1'b0, 32'h0);
    tick();
    outChk("s4.quiet", 1'b0, 32'h0);
    act = 3'b100;
    tick();
    tick();
    hold(16);
    tick();
    chk("s4.ch2Fsr", {31'b0, fsr}, 32'd1);
    chk("s4.ch2Gid", {30'b0, gid}, 32'd2);
    // Fill while stalled, then push into a full FIFO with a same-cycle pop
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stb = 3'b100; chData[95:64] = 32'hB000_0000 + i;
      tick();
      outChk("s5.stalled", 1'b0, 32'h0);
    end
    rdy = 1'b1; stb = 3'b100; chData[95:64] = 32'hB000_0004;
    tick();
    outChk("s5a.w0", 1'b1, 32'hB000_0000);
    chk("s5a.noOvf", {31'b0, ovf}, 32'd0);
    stb = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      outChk($sformatf("s5a.w%0d", i), 1'b1, 32'hB000_0000 + i);
    end
    tick();
    outChk("s5a.done", 1'b0, 32'h0);
    chk("s5a.ovfStill0", {31'b0, ovf}, 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stb = 3'b100; chData[95:64] = 32'hC000_0000 + i;
      tick();
      chk($sformatf("s5b.ovf%0d", i), {31'b0, ovf}, {31'b0, i == 4});
    end
    stb = 3'b000; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      outChk($sformatf("s5b.w%0d", i), 1'b1, 32'hC000_0000 + i);
    end
    tick();
    outChk("s5b.dropped", 1'b0, 32'h0);
    chk("s5b.ovfSticky", {31'b0, ovf}, 32'd1);
    // Reset with two words buffered
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stb = 3'b100; chData[95:64] = 32'hD000_0000 + i;
      tick();
    end
    stb = 3'b000; reset = 1'b1; rdy = 1'b1;
    tick();
    outChk("s6.rstStb", 1'b0, 32'h0);
    chk("s6.rstData", cwd, 32'h0);
    chk("s6.rstOvf", {31'b0, ovf}, 32'd0);
    chk("s6.rstBusy", {31'b0, busy}, 32'd0);
    reset = 1'b0; act = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick();
      outChk("s6.noFlush", 1'b0, 32'h0);
    end
`ifdef CONFIG_ARB_WORDCOUNT_EN
    chk("wcAfterMidReset", wc, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
